// File: rtl/deserializer_if.sv
// Handshake/bus bundle between a serial source and the deserializer.
// master drives the frame strobe and bit stream; slave returns the rebuilt word and status.
interface deserializer_if #(
  parameter int unsigned SIZE = 8
);
  logic            start;
  logic            serial_in;
  logic [SIZE-1:0] data_out;
  logic            valid;
  logic            busy;
  logic            frame_err;

  modport master (
    output start, serial_in,
    input  data_out, valid, busy, frame_err
  );

  modport slave (
    input  start, serial_in,
    output data_out, valid, busy, frame_err
  );
endinterface

// File: rtl/deserializer.sv
// Serial-to-parallel receiver: rebuilds an LSB-first word aligned to a start strobe,
// pulses valid on completion and frame_err when a frame is cut short by a new start.
module deserializer #(
  parameter int unsigned SIZE = 8
) (
  input logic           clk,
  input logic           rst_n,
  deserializer_if.slave bus
);

  localparam int unsigned CW = $clog2(SIZE);

  typedef enum logic {
    IDLE,
    RECV
  } state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [SIZE-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      shreg         <= '0;
      bus.data_out  <= '0;
      bus.valid     <= 1'b0;
      bus.busy      <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      bus.valid     <= 1'b0;
      bus.frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state    <= RECV;
            cnt      <= '0;
            bus.busy <= 1'b1;
          end
        end
        RECV: begin
          // Completion wins over start so a back-to-back frame is not flagged as an abort.
          if (cnt == CW'(SIZE - 1)) begin
            bus.data_out <= {bus.serial_in, shreg[SIZE-1:1]};
            shreg        <= {bus.serial_in, shreg[SIZE-1:1]};
            bus.valid    <= 1'b1;
            cnt          <= '0;
            if (!bus.start) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end else if (bus.start) begin
            bus.frame_err <= 1'b1;
            cnt           <= '0;
          end else begin
            shreg <= {bus.serial_in, shreg[SIZE-1:1]};
            cnt   <= cnt + CW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: directed frames on an 8-bit instance plus
// random serializer-style loopback on 8- and 16-bit instances, scoreboarded.
module tb_deserializer;
  timeunit 1ns;
  timeprecision 100ps;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  deserializer_if #(.SIZE(8))  b8 ();
  deserializer_if #(.SIZE(16)) b16 ();

  deserializer #(.SIZE(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b8.slave)
  );

  deserializer #(.SIZE(16)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b16.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  exp8[$];
  logic [7:0]  obs8[$];
  logic [15:0] exp16[$];
  logic [15:0] obs16[$];
  int vc8 = 0, vc16 = 0, fe8 = 0, fe16 = 0, both = 0;

  // Capture every completed word and status pulse shortly after each edge.
  always @(posedge clk) begin
    #0.5;
    if (b8.valid) begin vc8++; obs8.push_back(b8.data_out); end
    if (b16.valid) begin vc16++; obs16.push_back(b16.data_out); end
    if (b8.frame_err) fe8++;
    if (b16.frame_err) fe16++;
    if ((b8.valid && b8.frame_err) || (b16.valid && b16.frame_err)) both++;
  end

  task automatic tick(input logic s8, input logic d8, input logic s16, input logic d16);
    @(negedge clk);
    b8.start = s8;   b8.serial_in = d8;
    b16.start = s16; b16.serial_in = d16;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    n_cmp++;
    if (b8.data_out !== 8'h00 || b8.valid !== 1'b0 || b8.busy !== 1'b0 || b8.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset8: data=%h v=%b b=%b fe=%b want 00 0 0 0", b8.data_out, b8.valid, b8.busy, b8.frame_err);
    end
    n_cmp++;
    if (b16.data_out !== 16'h0000 || b16.valid !== 1'b0 || b16.busy !== 1'b0 || b16.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset16: data=%h v=%b b=%b fe=%b want 0000 0 0 0", b16.data_out, b16.valid, b16.busy, b16.frame_err);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(0, 0, 0, 0);
    n_cmp++;
    if (b8.busy !== 1'b0 || b8.valid !== 1'b0 || b8.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release: b=%b v=%b fe=%b want 0 0 0", b8.busy, b8.valid, b8.frame_err);
    end
  endtask

  task automatic test_single();
    logic [7:0] w = 8'hA5;
    logic [7:0] e, got;
    exp8.push_back(w);
    tick(1, 0, 0, 0);
    n_cmp++;
    if (b8.busy !== 1'b1 || b8.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL single_start: busy=%b valid=%b want 1 0", b8.busy, b8.valid);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, w[i], 0, 0);
      if (i < 7) begin
        n_cmp++;
        if (b8.valid !== 1'b0 || b8.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL single_bit%0d: valid=%b busy=%b want 0 1", i, b8.valid, b8.busy);
        end
      end
    end
    n_cmp++;
    if (b8.valid !== 1'b1 || b8.busy !== 1'b0 || b8.data_out !== 8'hA5) begin
      n_bad++;
      $display("FAIL single_done: valid=%b busy=%b data=%h want 1 0 a5", b8.valid, b8.busy, b8.data_out);
    end
    tick(0, 1, 0, 0);
    n_cmp++;
    if (b8.valid !== 1'b0 || b8.data_out !== 8'hA5) begin
      n_bad++;
      $display("FAIL single_hold: valid=%b data=%h want 0 a5", b8.valid, b8.data_out);
    end
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      n_cmp++;
      if (obs8.size() == 0) begin
        n_bad++;
        $display("FAIL single_sb: no word observed, want %h", e);
      end else begin
        got = obs8.pop_front();
        if (got !== e) begin n_bad++; $display("FAIL single_sb: got %h want %h", got, e); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] a = 8'h3C;
    logic [7:0] b = 8'hC3;
    logic [7:0] e, got;
    int vc0 = vc8;
    int fe0 = fe8;
    exp8.push_back(a);
    exp8.push_back(b);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      tick(i == 7, a[i], 0, 0);
      if (i < 7) begin
        n_cmp++;
        if (b8.valid !== 1'b0 || b8.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_a_bit%0d: valid=%b busy=%b want 0 1", i, b8.valid, b8.busy);
        end
      end
    end
    n_cmp++;
    if (b8.valid !== 1'b1 || b8.data_out !== 8'h3C || b8.busy !== 1'b1 || b8.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_first: v=%b data=%h b=%b fe=%b want 1 3c 1 0", b8.valid, b8.data_out, b8.busy, b8.frame_err);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, b[i], 0, 0);
      if (i < 7) begin
        n_cmp++;
        if (b8.valid !== 1'b0 || b8.busy !== 1'b1) begin
          n_bad++;
          $display("FAIL b2b_b_bit%0d: valid=%b busy=%b want 0 1", i, b8.valid, b8.busy);
        end
      end
    end
    n_cmp++;
    if (b8.valid !== 1'b1 || b8.data_out !== 8'hC3 || b8.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_second: v=%b data=%h b=%b want 1 c3 0", b8.valid, b8.data_out, b8.busy);
    end
    tick(0, 0, 0, 0);
    n_cmp++;
    if (vc8 - vc0 !== 2 || fe8 - fe0 !== 0) begin
      n_bad++;
      $display("FAIL b2b_counts: valids=%0d errs=%0d want 2 0", vc8 - vc0, fe8 - fe0);
    end
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      n_cmp++;
      if (obs8.size() == 0) begin
        n_bad++;
        $display("FAIL b2b_sb: no word observed, want %h", e);
      end else begin
        got = obs8.pop_front();
        if (got !== e) begin n_bad++; $display("FAIL b2b_sb: got %h want %h", got, e); end
      end
    end
  endtask

  task automatic test_abort();
    logic [7:0] w = 8'h81;
    logic [7:0] z = 8'h5A;
    logic [7:0] e, got;
    int vc0 = vc8;
    int fe0 = fe8;
    exp8.push_back(w);
    exp8.push_back(z);
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 1, 0, 0);
    tick(1, 1, 0, 0);
    n_cmp++;
    if (b8.frame_err !== 1'b1 || b8.valid !== 1'b0 || b8.data_out !== 8'hC3 || b8.busy !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_flag: fe=%b v=%b data=%h b=%b want 1 0 c3 1", b8.frame_err, b8.valid, b8.data_out, b8.busy);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, w[i], 0, 0);
      if (i < 7) begin
        n_cmp++;
        if (b8.valid !== 1'b0 || b8.frame_err !== 1'b0 || b8.data_out !== 8'hC3) begin
          n_bad++;
          $display("FAIL abort_bit%0d: v=%b fe=%b data=%h want 0 0 c3", i, b8.valid, b8.frame_err, b8.data_out);
        end
      end
    end
    n_cmp++;
    if (b8.valid !== 1'b1 || b8.data_out !== 8'h81 || b8.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_word: v=%b data=%h fe=%b want 1 81 0", b8.valid, b8.data_out, b8.frame_err);
    end
    tick(0, 0, 0, 0);
    // start held for three edges: the first opens the frame, the next two abort it
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    n_cmp++;
    if (b8.frame_err !== 1'b1 || b8.valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_start: fe=%b v=%b want 1 0", b8.frame_err, b8.valid);
    end
    for (int i = 0; i < 8; i++) tick(0, z[i], 0, 0);
    n_cmp++;
    if (b8.valid !== 1'b1 || b8.data_out !== 8'h5A) begin
      n_bad++;
      $display("FAIL hold_word: v=%b data=%h want 1 5a", b8.valid, b8.data_out);
    end
    tick(0, 0, 0, 0);
    n_cmp++;
    if (vc8 - vc0 !== 2 || fe8 - fe0 !== 3) begin
      n_bad++;
      $display("FAIL abort_counts: valids=%0d errs=%0d want 2 3", vc8 - vc0, fe8 - fe0);
    end
    while (exp8.size() > 0) begin
      e = exp8.pop_front();
      n_cmp++;
      if (obs8.size() == 0) begin
        n_bad++;
        $display("FAIL abort_sb: no word observed, want %h", e);
      end else begin
        got = obs8.pop_front();
        if (got !== e) begin n_bad++; $display("FAIL abort_sb: got %h want %h", got, e); end
      end
    end
  endtask

  task automatic test_reset_midframe();
    int vc0 = vc8;
    tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (b8.data_out !== 8'h00 || b8.valid !== 1'b0 || b8.busy !== 1'b0 || b8.frame_err !== 1'b0) begin
      n_bad++;
      $display("FAIL midreset_async: data=%h v=%b b=%b fe=%b want 00 0 0 0", b8.data_out, b8.valid, b8.busy, b8.frame_err);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(0, 1, 0, 0);
      n_cmp++;
      if (b8.busy !== 1'b0 || b8.valid !== 1'b0 || b8.data_out !== 8'h00) begin
        n_bad++;
        $display("FAIL midreset_idle%0d: b=%b v=%b data=%h want 0 0 00", i, b8.busy, b8.valid, b8.data_out);
      end
    end
    n_cmp++;
    if (vc8 - vc0 !== 0 || obs8.size() !== 0) begin
      n_bad++;
      $display("FAIL midreset_count: valids=%0d queued=%0d want 0 0", vc8 - vc0, obs8.size());
    end
  endtask

  task automatic test_loopback();
    logic [7:0]  w8, e8, g8;
    logic [15:0] w16, e16, g16;
    int vc0 = vc8;
    int fe0 = fe8;
    int vd0 = vc16;
    int fd0 = fe16;
    for (int n = 0; n < 200; n++) begin
      w8 = 8'($urandom());
      exp8.push_back(w8);
      tick(1, 0, 0, 0);
      for (int i = 0; i < 8; i++) tick(0, w8[i], 0, 0);
      repeat ($urandom_range(0, 2)) tick(0, 1'($urandom()), 0, 0);
    end
    for (int n = 0; n < 200; n++) begin
      w16 = 16'($urandom());
      exp16.push_back(w16);
      tick(0, 0, 1, 0);
      for (int i = 0; i < 16; i++) tick(0, 0, 0, w16[i]);
      repeat ($urandom_range(0, 2)) tick(0, 0, 0, 1'($urandom()));
    end
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    while (exp8.size() > 0) begin
      e8 = exp8.pop_front();
      n_cmp++;
      if (obs8.size() == 0) begin
        n_bad++;
        $display("FAIL loop8_sb: no word observed, want %h", e8);
      end else begin
        g8 = obs8.pop_front();
        if (g8 !== e8) begin n_bad++; $display("FAIL loop8_sb: got %h want %h", g8, e8); end
      end
    end
    while (exp16.size() > 0) begin
      e16 = exp16.pop_front();
      n_cmp++;
      if (obs16.size() == 0) begin
        n_bad++;
        $display("FAIL loop16_sb: no word observed, want %h", e16);
      end else begin
        g16 = obs16.pop_front();
        if (g16 !== e16) begin n_bad++; $display("FAIL loop16_sb: got %h want %h", g16, e16); end
      end
    end
    n_cmp++;
    if (vc8 - vc0 !== 200 || fe8 - fe0 !== 0) begin
      n_bad++;
      $display("FAIL loop8_counts: valids=%0d errs=%0d want 200 0", vc8 - vc0, fe8 - fe0);
    end
    n_cmp++;
    if (vc16 - vd0 !== 200 || fe16 - fd0 !== 0) begin
      n_bad++;
      $display("FAIL loop16_counts: valids=%0d errs=%0d want 200 0", vc16 - vd0, fe16 - fd0);
    end
  endtask

  initial begin
    b8.start = 1'b0;  b8.serial_in = 1'b0;
    b16.start = 1'b0; b16.serial_in = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_midframe();
    test_loopback();
    n_cmp++;
    if (both !== 0) begin
      n_bad++;
      $display("FAIL valid_and_err: overlapping cycles=%0d want 0", both);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
